// File: rtl/hdmi_video_timing.sv
// Raster timing generator for the TMDS encoder: sync, data-enable, coordinates and RGB, all registered.
// Optional test-pattern generator enabled by defining HDMI_TEST_PATTERN_EN; otherwise rgb is held at zero.
module hdmi_video_timing #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        hdmi_pixel_clock,
    input  logic        reset,
    input  logic [1:0]  pattern_sel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        frame_start,
    output logic [7:0]  frame_count,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic        active;
    logic        hs_on;
    logic        vs_on;
    logic        at_origin;
    logic        first_pending;
    logic [7:0]  fc_next;
    logic [23:0] rgb_next;

    always_ff @(posedge hdmi_pixel_clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
        at_origin = (h_cnt == 12'd0) && (v_cnt == 11'd0);
        // The first frame after reset is frame 0, so its origin does not count.
        fc_next   = (at_origin && !first_pending) ? frame_count + 8'd1 : frame_count;
    end

`ifdef HDMI_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [11:0] BAR1 = 12'(BAR_W * 1);
    localparam logic [11:0] BAR2 = 12'(BAR_W * 2);
    localparam logic [11:0] BAR3 = 12'(BAR_W * 3);
    localparam logic [11:0] BAR4 = 12'(BAR_W * 4);
    localparam logic [11:0] BAR5 = 12'(BAR_W * 5);
    localparam logic [11:0] BAR6 = 12'(BAR_W * 6);
    localparam logic [11:0] BAR7 = 12'(BAR_W * 7);

    logic [1:0]  pat_q;
    logic [1:0]  pat_eff;
    logic [23:0] bar_rgb;

    // The select is taken at the origin itself so pixel (0,0) already shows the new pattern.
    assign pat_eff = at_origin ? pattern_sel : pat_q;

    always_ff @(posedge hdmi_pixel_clock) begin
        if (reset) begin
            pat_q <= 2'd0;
        end else if (at_origin) begin
            pat_q <= pattern_sel;
        end
    end

    always_comb begin
        if      (h_cnt < BAR1) bar_rgb = 24'hFFFFFF;
        else if (h_cnt < BAR2) bar_rgb = 24'hFFFF00;
        else if (h_cnt < BAR3) bar_rgb = 24'h00FFFF;
        else if (h_cnt < BAR4) bar_rgb = 24'h00FF00;
        else if (h_cnt < BAR5) bar_rgb = 24'hFF00FF;
        else if (h_cnt < BAR6) bar_rgb = 24'hFF0000;
        else if (h_cnt < BAR7) bar_rgb = 24'h0000FF;
        else                   bar_rgb = 24'h000000;
    end

    always_comb begin
        rgb_next = 24'h000000;
        if (active) begin
            case (pat_eff)
                2'd0:    rgb_next = bar_rgb;
                2'd1:    rgb_next = {h_cnt[7:0], v_cnt[7:0], fc_next};
                2'd2:    rgb_next = (h_cnt[4] ^ v_cnt[4]) ? 24'h000000 : 24'hFFFFFF;
                default: rgb_next = 24'hFFFFFF;
            endcase
        end
    end
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = ^pattern_sel;
    assign rgb_next = 24'h000000;
`endif

    always_ff @(posedge hdmi_pixel_clock) begin
        if (reset) begin
            de            <= 1'b0;
            frame_start   <= 1'b0;
            hsync         <= ~HSYNC_POL;
            vsync         <= ~VSYNC_POL;
            pixel_x       <= '0;
            pixel_y       <= '0;
            frame_count   <= '0;
            rgb           <= '0;
            first_pending <= 1'b1;
        end else begin
            de          <= active;
            frame_start <= at_origin;
            hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            frame_count <= fc_next;
            rgb         <= rgb_next;
            if (at_origin) begin
                first_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing on a reduced raster (80x39 total) to keep frames short.
module tb_hdmi_video_timing;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 32, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk;
    logic        reset;
    logic [1:0]  pattern_sel;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] pixel_x;
    logic [10:0] pixel_y;
    logic [7:0]  frame_count;
    logic [23:0] rgb;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .hdmi_pixel_clock(clk),
        .reset(reset),
        .pattern_sel(pattern_sel),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_start(frame_start),
        .frame_count(frame_count),
        .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model state
    int         m_h = 0, m_v = 0;
    logic [7:0] m_fc = 8'd0;
    bit         m_first = 1'b1;
    int         m_lat = 0;

    logic [58:0] sb_q[$];

    // stats gathered from DUT outputs
    bit stats_en = 1'b0;
    int cyc = 0, fs_last = -1, fs_cnt = 0;
    int de_line0 = 0, hs_line0 = 0, hs_first_x = -1;
    int vs_low = 0, vs_first_y = -1, de_rise = 0;
    bit prev_de = 1'b0;

    function automatic logic [23:0] model_rgb(int pat, int x, int y, logic [7:0] fc);
        logic [11:0] xv;
        logic [10:0] yv;
        xv = 12'(x);
        yv = 11'(y);
`ifdef HDMI_TEST_PATTERN_EN
        case (pat)
            0: begin
                case (x / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {xv[7:0], yv[7:0], fc};
            2: return ((xv[4] ^ yv[4]) == 1'b0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'hFFFFFF;
        endcase
`else
        return (pat >= 0 && xv == xv && yv == yv && fc == fc) ? 24'h000000 : 24'h000000;
`endif
    endfunction

    task automatic run_cycle(input bit r, input logic [1:0] ps);
        logic [58:0] e, got;
        bit          ex_de, ex_hs, ex_vs, org;
        int          pat;
        reset       = r;
        pattern_sel = ps;
        if (r) begin
            e = {1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 11'd0, 8'd0, 24'd0};
            m_h = 0; m_v = 0; m_fc = 8'd0; m_first = 1'b1; m_lat = 0;
        end else begin
            org = (m_h == 0) && (m_v == 0);
            if (org) begin
                if (m_first) m_first = 1'b0;
                else         m_fc = m_fc + 8'd1;
                pat   = int'(ps);
                m_lat = int'(ps);
            end else begin
                pat = m_lat;
            end
            ex_de = (m_h < HA) && (m_v < VA);
            ex_hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            ex_vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            e = {ex_hs, ex_vs, ex_de, org, 12'(m_h), 11'(m_v), m_fc,
                 ex_de ? model_rgb(pat, m_h, m_v, m_fc) : 24'h000000};
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {hsync, vsync, de, frame_start, pixel_x, pixel_y, frame_count, rgb};
        check("outputs", 64'(got), 64'(sb_q.pop_front()));
        if (stats_en) begin
            if (pixel_y == 11'd0 && de) de_line0++;
            if (pixel_y == 11'd0 && !hsync) begin
                hs_line0++;
                if (hs_first_x < 0) hs_first_x = int'(pixel_x);
            end
            if (!vsync) begin
                vs_low++;
                if (vs_first_y < 0) vs_first_y = int'(pixel_y);
            end
            if (de && !prev_de) de_rise++;
            prev_de = de;
            if (frame_start) begin
                if (fs_last >= 0) check("fs_period", 64'(cyc - fs_last), 64'(FT));
                fs_last = cyc;
                fs_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic run_until(input int x, input int y, input logic [1:0] ps);
        int budget;
        budget = 2 * FT;
        while (!(m_h == x && m_v == y) && budget > 0) begin
            run_cycle(1'b0, ps);
            budget--;
        end
        if (budget == 0) check("run_until_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset       = 1'b1;
        pattern_sel = 2'd0;

        repeat (5) run_cycle(1'b1, 2'd0);
        check("rst_hsync", 64'(hsync), 64'd1);
        check("rst_vsync", 64'(vsync), 64'd1);
        check("rst_de", 64'(de), 64'd0);

        stats_en = 1'b1;
        run_cycle(1'b0, 2'd0);
        check("first_fs", 64'(frame_start), 64'd1);
        check("first_de", 64'(de), 64'd1);
        check("first_fc", 64'(frame_count), 64'd0);
        repeat (2 * FT - 1) run_cycle(1'b0, 2'd0);
        stats_en = 1'b0;
        check("de_line0", 64'(de_line0), 64'(2 * HA));
        check("hs_line0", 64'(hs_line0), 64'(2 * HS));
        check("hs_first_x", 64'(hs_first_x), 64'(HA + HF));
        check("vs_low", 64'(vs_low), 64'(2 * VS * HT));
        check("vs_first_y", 64'(vs_first_y), 64'(VA + VF));
        check("de_lines", 64'(de_rise), 64'(2 * VA));
        check("fs_count", 64'(fs_cnt), 64'd2);
        check("fc_end", 64'(frame_count), 64'd1);

        // mid-frame pattern change must wait for the next frame
        run_cycle(1'b0, 2'd0);
        check("fc_two", 64'(frame_count), 64'd2);
        run_until(10, 5, 2'd0);
        run_until(0, 0, 2'd3);
        run_cycle(1'b0, 2'd3);
`ifdef HDMI_TEST_PATTERN_EN
        check("solid_origin", 64'(rgb), 64'hFFFFFF);
`else
        check("solid_origin", 64'(rgb), 64'h000000);
`endif
        run_until(5, 5, 2'd3);
        run_until(0, 0, 2'd1);
        run_until(5, 5, 2'd1);
        run_until(0, 0, 2'd2);
        run_until(20, 20, 2'd2);

        run_until(30, 10, 2'd2);
        run_cycle(1'b1, 2'd2);
        check("rstp_de", 64'(de), 64'd0);
        check("rstp_xy", 64'({pixel_x, pixel_y}), 64'd0);
        run_cycle(1'b0, 2'd2);
        check("rstp_fs", 64'(frame_start), 64'd1);
        check("rstp_fc", 64'(frame_count), 64'd0);
        check("rstp_xy2", 64'({pixel_x, pixel_y}), 64'd0);
        repeat (3 * HT) run_cycle(1'b0, 2'd2);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
